// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit : PC generation, pipelined req/gnt instruction fetch, prefetch FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR      = 'h180
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  redirect_valid_i,
  input  logic [1:0]            redirect_mode_i,
  input  logic [ADDR_WIDTH-1:0] redirect_base_i,
  input  logic [25:0]           jmp_addr_i,
  input  logic [15:0]           branch_offset_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = PW + 2;

  localparam logic [SW-1:0]         DEPTH_S = SW'(FIFO_DEPTH);
  localparam logic [OW-1:0]         MAX_O   = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]         OW_ONE  = OW'(1);
  localparam logic [PW:0]           PTR_ONE = (PW + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  localparam logic [1:0] MODE_EXC    = 2'b00;
  localparam logic [1:0] MODE_JUMP   = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;
  localparam logic [1:0] MODE_REG    = 2'b11;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q,  resp_pc_d;
  logic [OW-1:0]         out_q,      out_d;
  logic [OW-1:0]         drop_q,     drop_d;
  logic [PW:0]           wptr_q,     wptr_d;
  logic [PW:0]           rptr_q,     rptr_d;
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc_q   [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] base4;
  logic [ADDR_WIDTH-1:0] jump_tgt;
  logic [ADDR_WIDTH-1:0] branch_off;
  logic [ADDR_WIDTH-1:0] target;
  logic [PW:0]           count;
  logic                  grant;
  logic                  rsp;
  logic                  push;
  logic                  pop;

  // ---------------------------------------------------------------------------
  // Redirect target computation
  // ---------------------------------------------------------------------------
  assign base4      = redirect_base_i + PC_STEP;
  assign branch_off = {{(ADDR_WIDTH-18){branch_offset_i[15]}}, branch_offset_i, 2'b00};

  generate
    if (ADDR_WIDTH > 28) begin : g_jump_hi
      assign jump_tgt = {base4[ADDR_WIDTH-1:28], jmp_addr_i, 2'b00};
    end else begin : g_jump_lo
      assign jump_tgt = {jmp_addr_i, 2'b00};
    end
  endgenerate

  always_comb begin
    target = EXC_VECTOR;
    case (redirect_mode_i)
      MODE_EXC:    target = EXC_VECTOR;
      MODE_JUMP:   target = jump_tgt;
      MODE_BRANCH: target = base4 + branch_off;
      MODE_REG:    target = {reg_addr_i[ADDR_WIDTH-1:2], 2'b00};
      default:     target = EXC_VECTOR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue gating: every outstanding request holds a reserved FIFO slot
  // ---------------------------------------------------------------------------
  assign count       = wptr_q - rptr_q;
  assign imem_req_o  = !rst && !redirect_valid_i && (out_q < MAX_O) &&
                       ((SW'(out_q) + SW'(count)) < DEPTH_S);
  assign imem_addr_o = fetch_pc_q;

  assign grant = imem_req_o && imem_gnt_i;
  assign rsp   = imem_rvalid_i && (out_q != '0);
  assign push  = rsp && (drop_q == '0) && !redirect_valid_i;
  assign pop   = instr_valid_o && instr_ready_i;

  assign instr_valid_o = (wptr_q != rptr_q);
  assign instr_o       = mem_data_q[rptr_q[PW-1:0]];
  assign instr_pc_o    = mem_pc_q[rptr_q[PW-1:0]];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + (grant ? OW_ONE : '0) - (rsp ? OW_ONE : '0);
    drop_d     = drop_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    if (redirect_valid_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc_d = target;
      resp_pc_d  = target;
      drop_d     = out_q - (rsp ? OW_ONE : '0);
      wptr_d     = '0;
      rptr_d     = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (rsp) begin
        if (drop_q != '0) begin
          drop_d = drop_q - OW_ONE;
        end else begin
          resp_pc_d = resp_pc_q + PC_STEP;
          wptr_d    = wptr_q + PTR_ONE;
        end
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else if (push) begin
      mem_data_q[wptr_q[PW-1:0]] <= imem_rdata_i;
      mem_pc_q[wptr_q[PW-1:0]]   <= resp_pc_q;
    end
  end

endmodule
`default_nettype wire
